// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall-bus encoding, exception/ERET redirection
// with flush deferral while the data bus is busy, and a saturating stall counter.
module pipeline_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mem_bus_busy,
  input  logic        excp_valid,
  input  logic [31:0] excp_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [5:0]  stall_req;

  // Deepest requesting stage wins; every earlier stage freezes with it.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)      stall_req = 6'b011111;
    else if (stallreq_ex)  stall_req = 6'b001111;
    else if (stallreq_id)  stall_req = 6'b000111;
    else if (stallreq_if)  stall_req = 6'b000011;
  end

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    new_pc_d  = new_pc_q;
    stall     = 6'b000000;
    flush     = 1'b0;
    new_pc    = new_pc_q;
    case (state_q)
      IDLE: begin
        if (excp_valid && !mem_bus_busy) begin
          flush    = 1'b1;
          new_pc   = excp_target;
          new_pc_d = excp_target;
        end else if (excp_valid) begin
          pend_pc_d = excp_target;
          stall     = 6'b111111;
          state_d   = DRAIN;
        end else begin
          stall = stall_req;
        end
      end
      // Later exceptions are ignored here: the first one owns the redirect.
      DRAIN: begin
        stall = 6'b111111;
        if (!mem_bus_busy) state_d = FLUSH;
      end
      FLUSH: begin
        flush    = 1'b1;
        new_pc   = pend_pc_q;
        new_pc_d = pend_pc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall[0] && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_pc_q     <= 32'h0000_0000;
      new_pc_q      <= PC_RESET;
      stall_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      new_pc_q      <= new_pc_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
